counter_updown: RTL
===================

// Module: counter_updown
// PURPOSE
//  Parametrised bounded counter; successor to the fixed up-saturating counter.
//  Counts up or down inside [InitVal, EndVal] with runtime direction, step,
//  wrap/saturate mode, synchronous load and boundary flags.
//  Drop-in timebase/index generator for datapath blocks and formal harnesses.
// PARAMETERS
//  Width      32  counter/data width in bits
//  StepWidth   8  width of Step_i
//  InitVal     8  lower bound and reset value; InitVal < EndVal required
//  EndVal     64  upper bound; EndVal < 2**Width required
// PORTS
//  Clk_i      in   1          single clock, rising edge
//  Reset_n_i  in   1          asynchronous, active-low reset
//  En_i       in   1          count enable
//  Dir_i      in   1          1 = up, 0 = down
//  Wrap_i     in   1          1 = wrap at bound, 0 = saturate at bound
//  Load_i     in   1          synchronous load strobe
//  LoadVal_i  in   Width      load value
//  Step_i     in   StepWidth  increment/decrement per enabled cycle
//  Data_o     out  Width      current count (registered)
//  AtInit_o   out  1          Data_o == InitVal (combinational from Data_o)
//  AtEnd_o    out  1          Data_o == EndVal (combinational from Data_o)
//  Wrapped_o  out  1          registered 1-cycle pulse: last update wrapped
// BEHAVIOUR
//  Reset (async assert, any time): Data_o=InitVal, Wrapped_o=0, AtInit_o=1,
//   AtEnd_o=0. Release is synchronous to Clk_i; first update on next edge.
//  Latency: one cycle from inputs to Data_o/Wrapped_o; flags follow Data_o.
//  Priority per edge: Load_i > En_i > hold.
//  Load: Data_o <= clamp(LoadVal_i): <InitVal -> InitVal, >EndVal -> EndVal.
//   Wrapped_o=0. Load ignores En_i, Dir_i, Wrap_i, Step_i.
//  Up (En_i & Dir_i): s = Data_o + Step_i computed in Width+1 bits (no overflow).
//   s <= EndVal -> Data_o<=s. Else Wrap_i=1 -> Data_o<=InitVal, Wrapped_o=1;
//   Wrap_i=0 -> Data_o<=EndVal, Wrapped_o=0.
//  Down (En_i & !Dir_i): d = Data_o - Step_i in Width+1 bits, signed compare.
//   d >= InitVal -> Data_o<=d. Else Wrap_i=1 -> Data_o<=EndVal, Wrapped_o=1;
//   Wrap_i=0 -> Data_o<=InitVal, Wrapped_o=0.
//  Wrap discards overshoot (lands exactly on opposite bound).
//  Step_i=0 with En_i=1: hold, Wrapped_o=0.
//  Hold (no Load_i, no En_i): Data_o stable, Wrapped_o=0.
//  Saturated hold: at EndVal counting up with Wrap_i=0, Data_o stays EndVal
//   indefinitely; likewise InitVal counting down.
//  Invariant: InitVal <= Data_o <= EndVal on every cycle, incl. after load.
//  Dir_i/Wrap_i may change every cycle; only values at the edge matter.
// STRUCTURE
//  counter_pkg: typedef enum logic {DIR_DOWN, DIR_UP} dir_t;
//   typedef enum logic {MODE_SAT, MODE_WRAP} mode_t; parameter-check macros.
//  Sub-module counter_step_calc: combinational next-value + wrap flag from
//   (Data, Step, Dir, Wrap, bounds); top holds regs, load clamp, flags.
//  Elaboration-time check: InitVal < EndVal, EndVal < 2**Width.
// TESTING (defaults Width=32, StepWidth=8, InitVal=8, EndVal=64)
//  Reset, En=1 Dir=1 Step=1 Wrap=0 -> 8,9,..,64 then 64 held; AtEnd_o=1 at 64.
//  Data=60, Dir=1 Step=8 Wrap=1 -> next Data=8, Wrapped_o=1 for one cycle.
//  Data=10, Dir=0 Step=5 Wrap=0 -> Data=8 (saturate), Wrapped_o=0, AtInit_o=1.
//  Load=1 LoadVal=200 with En=1 -> Data=64; LoadVal=3 -> Data=8.
//  Data=30, Reset_n_i low mid-cycle -> Data=8 immediately, before next edge.
//  Formal: invariant bounds, up/down step properties, Wrapped_o only on wrap.

Source files
------------

// File: rtl/counter_pkg.sv
// counter_pkg: shared direction/mode encodings and elaboration-time parameter sanity check.
package counter_pkg;

    typedef enum logic {DIR_DOWN, DIR_UP} dir_t;
    typedef enum logic {MODE_SAT, MODE_WRAP} mode_t;

    function automatic bit params_ok(input int unsigned w, input int unsigned sw,
                                     input longint unsigned lo, input longint unsigned hi);
        return lo < hi && sw <= w && (w >= 64 || hi < (64'd1 << w));
    endfunction

endpackage

// File: rtl/counter_step_calc.sv
// counter_step_calc: combinational next count and wrap flag for one enabled step.
module counter_step_calc
    import counter_pkg::*;
#(
    parameter int unsigned     Width     = 32,
    parameter int unsigned     StepWidth = 8,
    parameter longint unsigned InitVal   = 8,
    parameter longint unsigned EndVal    = 64
) (
    input  logic [Width-1:0]     data,
    input  logic [StepWidth-1:0] step,
    input  dir_t                 dir,
    input  mode_t                mode,
    output logic [Width-1:0]     next,
    output logic                 wrapped
);

    localparam logic [Width-1:0] Lo = Width'(InitVal);
    localparam logic [Width-1:0] Hi = Width'(EndVal);

    logic [Width:0] room;
    logic           over;

    // Distance to the bound in the travel direction; stepping past it means overshoot.
    always_comb begin
        room    = {1'b0, dir == DIR_UP ? Hi - data : data - Lo};
        over    = (Width+1)'(step) > room;
        next    = !over ? (dir == DIR_UP ? data + Width'(step) : data - Width'(step))
                        : ((dir == DIR_UP) == (mode == MODE_WRAP) ? Lo : Hi);
        wrapped = over && mode == MODE_WRAP;
    end

endmodule

// File: rtl/counter_updown.sv
// counter_updown: bounded up/down counter with runtime step, wrap/saturate mode,
// clamped synchronous load and boundary flags.
module counter_updown
    import counter_pkg::*;
#(
    parameter int unsigned     Width     = 32,
    parameter int unsigned     StepWidth = 8,
    parameter longint unsigned InitVal   = 8,
    parameter longint unsigned EndVal    = 64
) (
    input  logic                 Clk_i,
    input  logic                 Reset_n_i,
    input  logic                 En_i,
    input  logic                 Dir_i,
    input  logic                 Wrap_i,
    input  logic                 Load_i,
    input  logic [Width-1:0]     LoadVal_i,
    input  logic [StepWidth-1:0] Step_i,
    output logic [Width-1:0]     Data_o,
    output logic                 AtInit_o,
    output logic                 AtEnd_o,
    output logic                 Wrapped_o
);

    localparam logic [Width-1:0] Lo = Width'(InitVal);
    localparam logic [Width-1:0] Hi = Width'(EndVal);

    if (!params_ok(Width, StepWidth, InitVal, EndVal)) begin : g_param_check
        $error("counter_updown: need InitVal < EndVal < 2**Width and StepWidth <= Width");
    end

    logic [Width-1:0] step_next;
    logic             step_wrapped;
    logic [Width-1:0] load_clamped;

    counter_step_calc #(
        .Width    (Width),
        .StepWidth(StepWidth),
        .InitVal  (InitVal),
        .EndVal   (EndVal)
    ) u_step_calc (
        .data   (Data_o),
        .step   (Step_i),
        .dir    (dir_t'(Dir_i)),
        .mode   (mode_t'(Wrap_i)),
        .next   (step_next),
        .wrapped(step_wrapped)
    );

    always_comb load_clamped = LoadVal_i < Lo ? Lo : (LoadVal_i > Hi ? Hi : LoadVal_i);

    always_ff @(posedge Clk_i or negedge Reset_n_i) begin
        if (!Reset_n_i) begin
            Data_o    <= Lo;
            Wrapped_o <= 1'b0;
        end else if (Load_i) begin
            Data_o    <= load_clamped;
            Wrapped_o <= 1'b0;
        end else if (En_i) begin
            Data_o    <= step_next;
            Wrapped_o <= step_wrapped;
        end else begin
            Wrapped_o <= 1'b0;
        end
    end

    assign AtInit_o = Data_o == Lo;
    assign AtEnd_o  = Data_o == Hi;

endmodule
